nmea_frame_ctrl: RTL and testbench

Framing and buffer controller between the UART character receiver and the GPS sentence consumers. It parses the NMEA byte stream and verifies the XOR checksum. Verified sentence bodies go into a two-entry ping-pong buffer, which a downstream reader drains through a random-access read port and a release handshake. Bad or unbufferable sentences are discarded and reported on a one-cycle error pulse.

---
 rtl/nmea_frame_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_nmea_frame_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/nmea_frame_ctrl.sv
// nmea_frame_ctrl: NMEA sentence framer with XOR checksum check and a
// two-entry ping-pong body buffer drained through a random-access read port.
module nmea_frame_ctrl #(
  parameter int DEPTH = 80,
  parameter int AW    = 7
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_char,
  input  logic          i_char_valid,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic [AW-1:0] o_rd_len,
  output logic          o_rd_valid,
  input  logic          i_rd_done,
  output logic          o_busy,
  output logic          o_err,
  output logic [1:0]    o_err_code
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BODY   = 3'd1,
    CK_H   = 3'd2,
    CK_L   = 3'd3,
    EOL_CR = 3'd4,
    EOL_LF = 3'd5
  } state_t;

  localparam logic [1:0] ERR_CKSUM = 2'd0;
  localparam logic [1:0] ERR_OVFL  = 2'd1;
  localparam logic [1:0] ERR_FMT   = 2'd2;
  localparam logic [1:0] ERR_DROP  = 2'd3;

  state_t        state_reg, state_next;
  logic [7:0]    xor_reg, xor_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [7:0]    ck_reg, ck_next;
  logic          has_slot_reg, has_slot_next;
  logic          wr_sel_reg, rd_sel_reg;
  logic          err_reg, err_next;
  logic [1:0]    code_reg, code_next;
  logic          mem_we, commit, release_ok;
  logic [4:0]    nib;
  logic          is_print;

  logic [1:0]    full_vec;
  logic [AW-1:0] len_arr [2];
  logic [7:0]    rd_word_arr [2];
  logic          rd_hit_reg, rd_pick_reg;

  // Hex digit decode; bit 4 flags a legal uppercase hex digit.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else return 5'd0;
  endfunction

  assign nib        = hex_nib(i_char);
  assign is_print   = (i_char >= 8'h20) && (i_char <= 8'h7E);
  assign release_ok = i_rd_done && full_vec[rd_sel_reg];

  // Writer FSM next-state: parse one char per strobe, flag errors, request commit.
  always_comb begin
    state_next    = state_reg;
    xor_next      = xor_reg;
    cnt_next      = cnt_reg;
    ck_next       = ck_reg;
    has_slot_next = has_slot_reg;
    mem_we        = 1'b0;
    commit        = 1'b0;
    err_next      = 1'b0;
    code_next     = 2'd0;
    if (i_char_valid) begin
      if (i_char == 8'h24) begin
        // '$' always starts a sentence; mid-sentence it also aborts the old one.
        if (state_reg != IDLE) begin
          err_next  = 1'b1;
          code_next = ERR_FMT;
        end
        state_next    = BODY;
        xor_next      = 8'h00;
        cnt_next      = '0;
        has_slot_next = ~full_vec[wr_sel_reg];
      end else begin
        case (state_reg)
          IDLE: begin
            state_next = IDLE;
          end
          BODY: begin
            if (i_char == 8'h2A) begin
              state_next = CK_H;
            end else if (is_print) begin
              if (cnt_reg == AW'(DEPTH)) begin
                err_next   = 1'b1;
                code_next  = ERR_OVFL;
                state_next = IDLE;
              end else begin
                xor_next = xor_reg ^ i_char;
                mem_we   = has_slot_reg;
                cnt_next = cnt_reg + AW'(1);
              end
            end else begin
              err_next   = 1'b1;
              code_next  = ERR_FMT;
              state_next = IDLE;
            end
          end
          CK_H: begin
            if (nib[4]) begin
              ck_next    = {nib[3:0], ck_reg[3:0]};
              state_next = CK_L;
            end else begin
              err_next   = 1'b1;
              code_next  = ERR_FMT;
              state_next = IDLE;
            end
          end
          CK_L: begin
            if (nib[4]) begin
              ck_next    = {ck_reg[7:4], nib[3:0]};
              state_next = EOL_CR;
            end else begin
              err_next   = 1'b1;
              code_next  = ERR_FMT;
              state_next = IDLE;
            end
          end
          EOL_CR: begin
            if (i_char == 8'h0D) begin
              state_next = EOL_LF;
            end else begin
              err_next   = 1'b1;
              code_next  = ERR_FMT;
              state_next = IDLE;
            end
          end
          EOL_LF: begin
            state_next = IDLE;
            if (i_char != 8'h0A) begin
              err_next  = 1'b1;
              code_next = ERR_FMT;
            end else if (ck_reg != xor_reg) begin
              err_next  = 1'b1;
              code_next = ERR_CKSUM;
            end else if (!has_slot_reg) begin
              err_next  = 1'b1;
              code_next = ERR_DROP;
            end else begin
              commit = 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end
    end
  end

  // Writer state, selectors and registered error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      xor_reg      <= 8'h00;
      cnt_reg      <= '0;
      ck_reg       <= 8'h00;
      has_slot_reg <= 1'b0;
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      err_reg      <= 1'b0;
      code_reg     <= 2'd0;
    end else begin
      state_reg    <= state_next;
      xor_reg      <= xor_next;
      cnt_reg      <= cnt_next;
      ck_reg       <= ck_next;
      has_slot_reg <= has_slot_next;
      err_reg      <= err_next;
      code_reg     <= code_next;
      if (commit)     wr_sel_reg <= ~wr_sel_reg;
      if (release_ok) rd_sel_reg <= ~rd_sel_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [7:0]    mem [DEPTH];
      logic [7:0]    rd_word_reg;
      logic          full_reg;
      logic [AW-1:0] len_reg;

      // Body storage: plain array with synchronous write and registered read.
      always_ff @(posedge i_clk) begin
        if (mem_we && (wr_sel_reg == 1'(gi))) mem[cnt_reg] <= i_char;
        rd_word_reg <= mem[i_rd_addr];
      end

      // Entry status: filled on commit, freed on release of the read entry.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          full_reg <= 1'b0;
          len_reg  <= '0;
        end else if (commit && (wr_sel_reg == 1'(gi))) begin
          full_reg <= 1'b1;
          len_reg  <= cnt_reg;
        end else if (release_ok && (rd_sel_reg == 1'(gi))) begin
          full_reg <= 1'b0;
        end
      end

      assign full_vec[gi]    = full_reg;
      assign len_arr[gi]     = len_reg;
      assign rd_word_arr[gi] = rd_word_reg;
    end
  endgenerate

  // Read-side qualifiers captured alongside the memory read so data follows the sampled entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_hit_reg  <= 1'b0;
      rd_pick_reg <= 1'b0;
    end else begin
      rd_hit_reg  <= (i_rd_addr < len_arr[rd_sel_reg]);
      rd_pick_reg <= rd_sel_reg;
    end
  end

  assign o_rd_data  = rd_hit_reg ? rd_word_arr[rd_pick_reg] : 8'h00;
  assign o_rd_len   = len_arr[rd_sel_reg];
  assign o_rd_valid = full_vec[rd_sel_reg];
  assign o_busy     = (state_reg != IDLE);
  assign o_err      = err_reg;
  assign o_err_code = code_reg;

endmodule

// File: tb/tb_nmea_frame_ctrl.sv
// tb_nmea_frame_ctrl: directed scenarios for the NMEA framer and ping-pong buffer.
module tb_nmea_frame_ctrl;
  localparam int DEPTH = 80;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    i_char = 8'h00;
  logic          i_char_valid = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic [7:0]    o_rd_data;
  logic [AW-1:0] o_rd_len;
  logic          o_rd_valid;
  logic          i_rd_done = 1'b0;
  logic          o_busy;
  logic          o_err;
  logic [1:0]    o_err_code;

  int   total = 0;
  int   bad = 0;
  int   err_cnt = 0;
  logic [1:0] err_code_seen = 2'd0;
  logic [7:0] rdat;

  nmea_frame_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_char(i_char), .i_char_valid(i_char_valid),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_len(o_rd_len),
    .o_rd_valid(o_rd_valid), .i_rd_done(i_rd_done), .o_busy(o_busy),
    .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  // Drive one char per cycle; sample the error pulse caused by the previous char.
  task automatic put(input logic [7:0] c);
    @(negedge clk);
    if (o_err) begin err_cnt++; err_code_seen = o_err_code; end
    i_char = c;
    i_char_valid = 1'b1;
  endtask

  task automatic flush();
    @(negedge clk);
    if (o_err) begin err_cnt++; err_code_seen = o_err_code; end
    i_char_valid = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
    flush();
    $display("tx: sentence of %0d chars, errs so far %0d", s.len(), err_cnt);
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    @(negedge clk);
    i_rd_addr = AW'(a);
    @(negedge clk);
    d = o_rd_data;
  endtask

  task automatic done();
    @(negedge clk);
    i_rd_done = 1'b1;
    @(negedge clk);
    i_rd_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", o_rd_valid); end
    total++; if (o_rd_len !== 7'd0) begin bad++; $display("FAIL rst_len got=%0d exp=0", o_rd_len); end
    total++; if (o_rd_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", o_rd_data); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", o_busy); end
    total++; if ({o_err, o_err_code} !== 3'b000) begin bad++; $display("FAIL rst_err got=%b exp=000", {o_err, o_err_code}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_commit();
    err_cnt = 0;
    send("$AB*03\r\n");
    total++; if (o_rd_valid !== 1'b1) begin bad++; $display("FAIL commit_valid got=%0d exp=1", o_rd_valid); end
    total++; if (o_rd_len !== 7'd2) begin bad++; $display("FAIL commit_len got=%0d exp=2", o_rd_len); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL commit_noerr got=%0d exp=0", err_cnt); end
    rd(0, rdat);
    total++; if (rdat !== 8'h41) begin bad++; $display("FAIL commit_d0 got=%h exp=41", rdat); end
    rd(1, rdat);
    total++; if (rdat !== 8'h42) begin bad++; $display("FAIL commit_d1 got=%h exp=42", rdat); end
    rd(2, rdat);
    total++; if (rdat !== 8'h00) begin bad++; $display("FAIL commit_d2 got=%h exp=00", rdat); end
    done();
    total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL commit_release got=%0d exp=0", o_rd_valid); end
  endtask

  task automatic test_checksum();
    err_cnt = 0;
    send("$AB*04\r\n");
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL cksum_cnt got=%0d exp=1", err_cnt); end
    total++; if (err_code_seen !== 2'd0) begin bad++; $display("FAIL cksum_code got=%0d exp=0", err_code_seen); end
    total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL cksum_valid got=%0d exp=0", o_rd_valid); end
    done();
  endtask

  task automatic test_back_to_back();
    err_cnt = 0;
    send("$AB*03\r\n");
    send("$ABC*40\r\n");
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL b2b_noerr got=%0d exp=0", err_cnt); end
    send("$AB*03\r\n");
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL drop_cnt got=%0d exp=1", err_cnt); end
    total++; if (err_code_seen !== 2'd3) begin bad++; $display("FAIL drop_code got=%0d exp=3", err_code_seen); end
    total++; if (o_rd_len !== 7'd2) begin bad++; $display("FAIL b2b_len0 got=%0d exp=2", o_rd_len); end
    done();
    total++; if (o_rd_len !== 7'd3) begin bad++; $display("FAIL b2b_len1 got=%0d exp=3", o_rd_len); end
    rd(0, rdat);
    total++; if (rdat !== 8'h41) begin bad++; $display("FAIL b2b_d0 got=%h exp=41", rdat); end
    rd(1, rdat);
    total++; if (rdat !== 8'h42) begin bad++; $display("FAIL b2b_d1 got=%h exp=42", rdat); end
    rd(2, rdat);
    total++; if (rdat !== 8'h43) begin bad++; $display("FAIL b2b_d2 got=%h exp=43", rdat); end
    done();
    total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", o_rd_valid); end
  endtask

  task automatic test_resync();
    err_cnt = 0;
    send("$AB*0$ABC*40\r\n");
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL resync_cnt got=%0d exp=1", err_cnt); end
    total++; if (err_code_seen !== 2'd2) begin bad++; $display("FAIL resync_code got=%0d exp=2", err_code_seen); end
    total++; if (o_rd_valid !== 1'b1) begin bad++; $display("FAIL resync_valid got=%0d exp=1", o_rd_valid); end
    total++; if (o_rd_len !== 7'd3) begin bad++; $display("FAIL resync_len got=%0d exp=3", o_rd_len); end
    done();
  endtask

  task automatic test_format_overflow();
    err_cnt = 0;
    send("$AN*0f\r\n");
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL lower_cnt got=%0d exp=1", err_cnt); end
    total++; if (err_code_seen !== 2'd2) begin bad++; $display("FAIL lower_code got=%0d exp=2", err_code_seen); end
    err_cnt = 0;
    put(8'h24);
    for (int i = 0; i < DEPTH + 1; i++) put(8'h41);
    send("*00\r\n");
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL ovfl_cnt got=%0d exp=1", err_cnt); end
    total++; if (err_code_seen !== 2'd1) begin bad++; $display("FAIL ovfl_code got=%0d exp=1", err_code_seen); end
    total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL ovfl_valid got=%0d exp=0", o_rd_valid); end
    err_cnt = 0;
    send("$AN*0F\r\n");
    total++; if (err_cnt !== 0 || o_rd_len !== 7'd2) begin bad++; $display("FAIL an_commit got=%0d/%0d exp=0/2", err_cnt, o_rd_len); end
    rd(1, rdat);
    total++; if (rdat !== 8'h4E) begin bad++; $display("FAIL an_d1 got=%h exp=4e", rdat); end
    done();
    put(8'h24);
    for (int i = 0; i < DEPTH; i++) put(8'h41);
    send("*00\r\n");
    total++; if (err_cnt !== 0 || o_rd_len !== 7'd80) begin bad++; $display("FAIL full_commit got=%0d/%0d exp=0/80", err_cnt, o_rd_len); end
    rd(DEPTH - 1, rdat);
    total++; if (rdat !== 8'h41) begin bad++; $display("FAIL full_last got=%h exp=41", rdat); end
    rd(DEPTH, rdat);
    total++; if (rdat !== 8'h00) begin bad++; $display("FAIL full_past got=%h exp=00", rdat); end
    done();
  endtask

  task automatic test_reset_mid();
    err_cnt = 0;
    send("$AB*03\r\n");
    put(8'h24); put(8'h41); put(8'h42);
    @(negedge clk);
    i_char_valid = 1'b0;
    total++; if (o_busy !== 1'b1 || o_rd_valid !== 1'b1) begin bad++; $display("FAIL pre_rst got=%0d/%0d exp=1/1", o_busy, o_rd_valid); end
    rst = 1'b1;
    #1;
    total++; if ({o_busy, o_rd_valid, o_err} !== 3'b000) begin bad++; $display("FAIL mid_rst got=%b exp=000", {o_busy, o_rd_valid, o_err}); end
    total++; if (o_rd_len !== 7'd0 || o_rd_data !== 8'h00) begin bad++; $display("FAIL mid_rst_rd got=%0d/%h exp=0/00", o_rd_len, o_rd_data); end
    @(negedge clk);
    rst = 1'b0;
    done();
    total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL idle_done got=%0d exp=0", o_rd_valid); end
    send("$AB*03\r\n");
    total++; if (o_rd_valid !== 1'b1 || o_rd_len !== 7'd2) begin bad++; $display("FAIL post_rst got=%0d/%0d exp=1/2", o_rd_valid, o_rd_len); end
    rd(0, rdat);
    total++; if (rdat !== 8'h41) begin bad++; $display("FAIL post_rst_d0 got=%h exp=41", rdat); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL post_rst_err got=%0d exp=0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_checksum();
    test_back_to_back();
    test_resync();
    test_format_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
